// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitrating mux family.
package arb_pkg;

  // Arbitration policy: round-robin, or fixed priority with index 0 highest.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Width of an index into n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or fixed priority.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N_CH     = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       CW       = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CW-1:0]   gnt_idx,
  output logic            any
);

  int   start_s;
  logic hit_s;

  // Two-pass search: first indices at or above the start point, then the
  // wrapped indices below it; the first requester found wins.
  always_comb begin
    start_s = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      hit_s   = !any && req[i] && (i >= start_s);
      gnt[i]  = gnt[i] | hit_s;
      gnt_idx = hit_s ? CW'(i) : gnt_idx;
      any     = any | hit_s;
    end
    for (int i = 0; i < N_CH; i++) begin
      hit_s   = !any && req[i] && (i < start_s);
      gnt[i]  = gnt[i] | hit_s;
      gnt_idx = hit_s ? CW'(i) : gnt_idx;
      any     = any | hit_s;
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N_CH-channel arbitrating mux feeding a single registered valid/ready slot.
module rr_mux_reg
  import arb_pkg::*;
#(
  parameter int        WIDTH    = 32,
  parameter int        N_CH     = 4,
  parameter arb_mode_e ARB_MODE = ARB_RR,
  localparam int       CW       = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int            SW      = clog2_min1(N_CH * WIDTH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  logic [N_CH-1:0]  gnt_s;
  logic [CW-1:0]    gnt_idx_s;
  logic             any_s;
  logic             free_s;
  logic             ld_s;
  logic [SW-1:0]    sel_base_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [CW-1:0]    next_ptr_s;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;

  rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  // Slot availability, handshake and winner data select.
  always_comb begin
    free_s     = ~out_valid_q | out_ready;
    ld_s       = free_s & any_s;
    in_ready   = rst ? '0 : (gnt_s & {N_CH{free_s}});
    sel_base_s = SW'(int'(gnt_idx_s) * WIDTH);
    sel_data_s = in_data[sel_base_s +: WIDTH];
    next_ptr_s = (gnt_idx_s == LAST_CH) ? '0 : (gnt_idx_s + CW'(1));
  end

  // Next state of the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (ld_s) begin
      out_data_d  = sel_data_s;
      out_ch_d    = gnt_idx_s;
      out_valid_d = 1'b1;
      rr_ptr_d    = (ARB_MODE == ARB_RR) ? next_ptr_s : '0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the fixed mux2/mux4/mux8 set. N_CH-channel, WIDTH-bit arbitrating mux with per-channel valid/ready inputs and one registered valid/ready output.
- Used in the core wherever several requesters share one path, e.g. fetch and load/store requests to a single memory port, or writeback sources to the register file.
- Arbitration is either round-robin or fixed priority, selected by parameter.

Parameters:
- WIDTH, 32, data bits per channel.
- N_CH, 4, number of input channels (1..16, need not be a power of two).
- ARB_MODE, ARB_RR, arb_mode_e: ARB_RR is round-robin; ARB_FIXED gives the lowest index highest priority.
- CW, max(1,$clog2(N_CH)), channel-index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel request.
- in_ready  out  N_CH  per-channel accept, one-hot or zero.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  CW  registered index of the channel that supplied out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is forced to all-zero while rst is high.
- Reset mid-operation: a held output word is discarded. No handshake completes in the cycle rst is asserted.
- Output slot: free = ~out_valid | out_ready.
- Grant (combinational): gnt = one-hot winner among in_valid.
  - ARB_FIXED: lowest set index wins.
  - ARB_RR: search starts at rr_ptr and wraps at N_CH-1 back to 0. The first set index wins.
- in_ready = gnt & {N_CH{free}}.
  - in_ready never depends on in_valid of another channel beyond the grant logic.
  - At most one bit of in_ready is set.
- Load: ld = free & |in_valid. On ld:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
  - ARB_RR only: rr_ptr <= (g==N_CH-1) ? 0 : g+1.
- Drain: out_valid & out_ready & ~|in_valid -> out_valid <= 0. out_data and out_ch keep their last values.
- Stall: out_valid & ~out_ready.
  - out_data and out_ch hold stable and in_ready = 0.
  - rr_ptr does not move.
- Simultaneous drain and load (out_valid & out_ready & |in_valid): new word loads in the same cycle. Full throughput is 1 word/cycle.
- Latency: accepted input appears on out_* the next cycle.
- rr_ptr update rules:
  - Advances only on an accepted transfer, never on idle cycles.
  - Unused in ARB_FIXED; held at 0.
- Non-power-of-two N_CH (e.g. 3): rr_ptr never takes values >= N_CH.
  - in_valid bits >= N_CH do not exist.
- N_CH=1: CW=1, out_ch is always 0. Behaves as a single register slice.
- Fairness (ARB_RR): with all channels continuously valid and out_ready=1, each channel is granted exactly once per N_CH cycles.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e.
  - function clog2_min1(int n), used for CW.
- Sub-module rr_arbiter #(N_CH, ARB_MODE) is purely combinational:
  - in: req[N_CH], ptr[CW].
  - out: gnt[N_CH] one-hot, gnt_idx[CW], any.
  - Reusable by future multi-port arbiters.
- rr_mux_reg holds:
  - the output register, rr_ptr register, ready logic and data select.
  - data select uses an indexed part-select on gnt_idx, not a case statement.

Test Plan:
1. Reset mid-transfer: assert rst while out_valid=1. Require out_valid=0, out_data=0 and in_ready=0 immediately (async), and rr_ptr=0 after release.
2. RR fairness: N_CH=4, in_valid=4'b1111, out_ready=1 for 8 cycles. Require out_ch sequence 0,1,2,3,0,1,2,3 and one in_ready bit per cycle.
3. RR skip and wrap: N_CH=3, rr_ptr=2, in_valid=3'b011. Require the grant to go to ch0 and rr_ptr to become 1; then a ch1 request is granted.
4. Backpressure: data A on ch2 accepted, then out_ready=0 for 3 cycles with ch1 valid. Require out_data=A stable, out_ch=2 and in_ready=0 throughout, with ch1 accepted on the cycle out_ready returns to 1.
5. Fixed priority: ARB_FIXED, in_valid=4'b1010 held, out_ready=1. Require out_ch=1 every cycle and ch3 never granted.
6. Bubble/drain: a single word on ch0, then in_valid=0 and out_ready=1. Require out_valid to be 1 for exactly one cycle, then 0 with out_data unchanged.
